mod_add_tree_pipe: RTL and testbench

//  Pipelined, parametrised modular adder tree: reduces LANES residues (each < q) to one sum mod q.

---
 rtl/mod_add_tree_pipe_pkg.sv | 22 ++
 rtl/mod_add_tree_pipe_mod_add_unit.sv | 28 ++
 rtl/mod_add_tree_pipe.sv | 119 +++++++++++
 tb/tb_mod_add_tree_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_add_tree_pipe_pkg.sv
// Shared defaults and elaboration helpers for the pipelined modular adder tree.
package mod_add_tree_pipe_pkg;

  localparam int DATA_W_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit lanes_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mod_add_tree_pipe_mod_add_unit.sv
// Combinational modular adder: y = (a + b) mod q, valid when a, b < q.
module mod_add_unit
  import mod_add_tree_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0]   s;
  logic [DATA_W+1:0] d;
  logic              unused_d_bit;

  // NOTE: every variable written in always_comb is assigned on all paths,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    d = {1'b0, s} - {2'b00, q};
    y = d[DATA_W+1] ? s[DATA_W-1:0] : d[DATA_W-1:0];
  end

  // With a, b < q a non-negative difference is below q, so this bit is always 0.
  assign unused_d_bit = d[DATA_W];

endmodule

// File: rtl/mod_add_tree_pipe.sv
// Pipelined modular adder tree reducing LANES residues mod q, with per-packet accumulation.
module mod_add_tree_pipe
  import mod_add_tree_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       q,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data
);

  localparam int LVLS = clog2(LANES);

  if (!lanes_ok(LANES)) begin : g_lanes_chk
    $error("mod_add_tree_pipe: LANES must be a power of 2 and >= 2");
  end

  logic en;

  // Heap-numbered tree: node 1 is the root, children of node i are 2i and 2i+1,
  // indices LANES..2*LANES-1 are the input lanes themselves.
  logic [DATA_W-1:0] node_sum [1:LANES-1];
  logic [DATA_W-1:0] node_d   [1:LANES-1];
  logic [DATA_W-1:0] node_q   [1:LANES-1];

  logic [LVLS:1]     vld_d, vld_q, first_d, first_q, last_d, last_q;
  logic [DATA_W-1:0] acc_d, acc_q, acc_sum;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic              out_valid_d, out_valid_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  for (genvar i = 1; i < LANES; i++) begin : g_node
    logic [DATA_W-1:0] a, b;
    if (2 * i >= LANES) begin : g_leaf
      assign a = in_data[(2*i-LANES)*DATA_W +: DATA_W];
      assign b = in_data[(2*i+1-LANES)*DATA_W +: DATA_W];
    end else begin : g_inner
      assign a = node_q[2*i];
      assign b = node_q[2*i+1];
    end
    mod_add_unit #(.DATA_W(DATA_W)) u_add (.a(a), .b(b), .q(q), .y(node_sum[i]));
  end

  mod_add_unit #(.DATA_W(DATA_W)) u_acc_add (.a(acc_q), .b(node_q[1]), .q(q), .y(acc_sum));

  always_comb begin
    for (int i = 1; i < LANES; i++) begin
      node_d[i] = en ? node_sum[i] : node_q[i];
    end
  end

  always_comb begin
    vld_d       = vld_q;
    first_d     = first_q;
    last_d      = last_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (en) begin
      vld_d[1]   = in_valid;
      first_d[1] = in_first;
      last_d[1]  = in_last;
      for (int l = 2; l <= LVLS; l++) begin
        vld_d[l]   = vld_q[l-1];
        first_d[l] = first_q[l-1];
        last_d[l]  = last_q[l-1];
      end
      // A consumed output drops unless a new last beat replaces it this same cycle.
      out_valid_d = 1'b0;
      if (vld_q[LVLS]) begin
        acc_d = first_q[LVLS] ? node_q[1] : acc_sum;
        if (last_q[LVLS]) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_d;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: tree datapath registers carry no reset; the valid bits alone decide
  // whether their contents are ever consumed.
  always_ff @(posedge clk) begin
    node_q <= node_d;
  end

endmodule

// File: tb/tb_mod_add_tree_pipe.sv
// Scoreboard bench for mod_add_tree_pipe (LANES=8, DATA_W=32).
module tb_mod_add_tree_pipe;

  localparam int DATA_W = 32;
  localparam int LANES  = 8;
  localparam logic [DATA_W-1:0] Q0 = 32'd12289;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [DATA_W-1:0]       q;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_first;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;

  always #5 clk = ~clk;

  mod_add_tree_pipe #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .q(q),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  longint unsigned   exp_q[$];
  longint unsigned   acc_m;
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_out    = 0;
  logic [DATA_W-1:0] last_out;
  bit                rnd_on;

  function automatic longint unsigned lanes_sum(input logic [LANES*DATA_W-1:0] d,
                                                input longint unsigned m);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < LANES; k++) s += d[k*DATA_W +: DATA_W];
    return s % m;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] fill(input logic [DATA_W-1:0] v);
    return {LANES{v}};
  endfunction

  // Outputs are sampled on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    longint unsigned e;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got out_data=%0d, required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e[DATA_W-1:0]) begin
          n_fail++;
          $display("FAIL out_data: got %0d, required %0d", out_data, e);
        end
      end
      last_out = out_data;
      n_out++;
    end
  end

  task automatic send_beat(input logic [LANES*DATA_W-1:0] d, input logic first, input logic last);
    int g;
    longint unsigned ts;
    in_data  = d;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", g);
    end else begin
      ts    = lanes_sum(d, longint'(q));
      acc_m = first ? ts : (acc_m + ts) % longint'(q);
      if (last) exp_q.push_back(acc_m);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; q = Q0; in_valid = 1'b0; in_data = '0;
    in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1; acc_m = 0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    send_beat(fill(32'd12288), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL latency_cycle%0d: got out_valid=%b, required %b", i + 1, out_valid, i == 3);
      end
    end
    n_checks++;
    if (out_data !== 32'd12281) begin n_fail++; $display("FAIL single_sum: got %0d, required 12281", out_data); end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_multi_beat();
    int n0;
    n0 = n_out;
    send_beat(fill(32'd1), 1'b1, 1'b0);
    send_beat(fill(32'd1), 1'b0, 1'b0);
    send_beat(fill(32'd1), 1'b0, 1'b1);
    drain();
    n_checks++;
    if (n_out - n0 != 1) begin n_fail++; $display("FAIL multi_count: got %0d outputs, required 1", n_out - n0); end
    n_checks++;
    if (last_out !== 32'd24) begin n_fail++; $display("FAIL multi_sum: got %0d, required 24", last_out); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [DATA_W-1:0] held;
    n0 = n_out;
    fork
      begin
        logic [LANES*DATA_W-1:0] d;
        for (int i = 0; i < 20; i++) begin
          for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = (i * 131 + k * 977 + 7) % 12289;
          send_beat(d, 1'b1, 1'b1);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b, required 1", out_valid); end
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
          n_checks++;
          if (out_data !== held) begin n_fail++; $display("FAIL stall_hold: got %0d, required %0d", out_data, held); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (n_out - n0 != 20) begin n_fail++; $display("FAIL b2b_count: got %0d outputs, required 20", n_out - n0); end
  endtask

  task automatic test_async_reset();
    int g;
    int n0;
    out_ready = 1'b0;
    send_beat(fill(32'd100), 1'b1, 1'b1);
    send_beat(fill(32'd3), 1'b1, 1'b0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!out_valid && g < 50);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got out_valid=%b, required 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL async_rst_data: got %0d, required 0", out_data); end
    exp_q.delete();
    acc_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n0 = n_out;
    send_beat(fill(32'd5), 1'b0, 1'b1);
    drain();
    n_checks++;
    if (n_out - n0 != 1) begin n_fail++; $display("FAIL post_rst_count: got %0d, required 1", n_out - n0); end
    n_checks++;
    if (last_out !== 32'd40) begin n_fail++; $display("FAIL post_rst_sum: got %0d, required 40", last_out); end
  endtask

  task automatic test_wide_q();
    q = 32'hFFFF_FFFF;
    send_beat(fill(32'hFFFF_FFFE), 1'b1, 1'b0);
    send_beat(fill(32'hFFFF_FFFE), 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_out !== 32'hFFFF_FFEF) begin n_fail++; $display("FAIL wide_q_sum: got %0h, required ffffffef", last_out); end
    q = Q0;
  endtask

  task automatic run_random(input int n_pkt);
    logic [LANES*DATA_W-1:0] d;
    int len;
    bit drop_last, no_first;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int p = 0; p < n_pkt; p++) begin
      len       = $urandom_range(1, 6);
      drop_last = ($urandom_range(0, 9) == 0);
      no_first  = ($urandom_range(0, 19) == 0);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = $urandom_range(0, q - 1);
        send_beat(d, (b == 0) && !no_first, (b == len - 1) && !drop_last);
      end
    end
    rnd_on = 1'b0;
    idle(2);
    drain();
  endtask

  task automatic test_random();
    int n0;
    n0 = n_out;
    run_random(1500);
    q = 32'hF000_0007;
    run_random(1500);
    q = Q0;
    n_checks++;
    if (n_out - n0 < 1000) begin n_fail++; $display("FAIL random_outputs: got %0d, required at least 1000", n_out - n0); end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_multi_beat();
    test_back_to_back();
    test_async_reset();
    test_wide_q();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
